// File: rtl/vga_tile_compositor_pkg.sv
//------------------------------------------------------------------------------
// Module  : vga_tile_pkg
// Brief   : Shared highlight-mode constants and helper functions for the
//           VGA tile compositor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package vga_tile_pkg;

    // Highlight modes
    localparam logic [1:0] HL_NONE   = 2'b00;
    localparam logic [1:0] HL_BORDER = 2'b01;
    localparam logic [1:0] HL_TINT   = 2'b10;
    localparam logic [1:0] HL_BLINK  = 2'b11;

    // Half-and-half blend of one colour channel (channels up to 16 bits).
    // Each operand is halved first, so the sum can never overflow the channel.
    function automatic logic [15:0] half_blend(input logic [15:0] a, input logic [15:0] b);
        return (a >> 1) + (b >> 1);
    endfunction

    // True when every pixel of every tile has its own ROM address.
    function automatic bit rom_fits(input longint tiles, input longint tw,
                                    input longint th, input longint aw);
        return (tiles * tw * th) <= (longint'(1) << aw);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_tile_compositor_if.sv
//------------------------------------------------------------------------------
// Module  : vga_tile_compositor_if
// Brief   : Raster, highlight, image-ROM and RGB signals of the compositor.
//           slave = compositor side, master = timing generator / ROM side.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface vga_tile_compositor_if #(
    parameter int R_WIDTH        = 8,
    parameter int G_WIDTH        = 8,
    parameter int B_WIDTH        = 8,
    parameter int CNTR_WIDTH_H   = 11,
    parameter int CNTR_WIDTH_V   = 10,
    parameter int NUM_TILES      = 12,
    parameter int ROM_ADDR_WIDTH = 17
) ();
    localparam int RGB_W = R_WIDTH + G_WIDTH + B_WIDTH;

    logic [CNTR_WIDTH_H-1:0]   CounterX;
    logic [CNTR_WIDTH_V-1:0]   CounterY;
    logic                      PixValid;
    logic                      FrameStart;
    logic [NUM_TILES-1:0]      HighlightMask;
    logic [1:0]                HighlightMode;
    logic [RGB_W-1:0]          HighlightColor;
    logic [RGB_W-1:0]          BgColor;
    logic [ROM_ADDR_WIDTH-1:0] ROM_Addr;
    logic [RGB_W-1:0]          ROM_Data;
    logic [RGB_W-1:0]          RGB_Bus;
    logic                      RGB_Valid;

    modport slave (
        input  CounterX, CounterY, PixValid, FrameStart,
        input  HighlightMask, HighlightMode, HighlightColor, BgColor,
        input  ROM_Data,
        output ROM_Addr, RGB_Bus, RGB_Valid
    );

    modport master (
        output CounterX, CounterY, PixValid, FrameStart,
        output HighlightMask, HighlightMode, HighlightColor, BgColor,
        output ROM_Data,
        input  ROM_Addr, RGB_Bus, RGB_Valid
    );
endinterface

`default_nettype wire

// File: rtl/vga_tile_hit_decoder.sv
//------------------------------------------------------------------------------
// Module  : vga_tile_hit_decoder
// Brief   : Maps a raster position onto the tile grid with per-column and
//           per-row range compares. Look-ahead (combinational) index/offsets
//           feed the ROM address register; hit/index/border are registered.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_tile_hit_decoder #(
    parameter int CNTR_WIDTH_H = 11,
    parameter int CNTR_WIDTH_V = 10,
    parameter int TILE_W       = 100,
    parameter int TILE_H       = 100,
    parameter int TILE_COLS    = 4,
    parameter int TILE_ROWS    = 3,
    parameter int ORIGIN_X     = 40,
    parameter int ORIGIN_Y     = 40,
    parameter int GAP          = 20,
    parameter int BORDER_W     = 4,
    localparam int NUM_TILES   = TILE_COLS * TILE_ROWS,
    localparam int IDX_W       = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1,
    localparam int LX_W        = (TILE_W > 1) ? $clog2(TILE_W) : 1,
    localparam int LY_W        = (TILE_H > 1) ? $clog2(TILE_H) : 1
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic [CNTR_WIDTH_H-1:0] i_x,
    input  wire logic [CNTR_WIDTH_V-1:0] i_y,
    output logic                         o_hit_nxt,
    output logic [IDX_W-1:0]             o_index_nxt,
    output logic [LX_W-1:0]              o_lx_nxt,
    output logic [LY_W-1:0]              o_ly_nxt,
    output logic                         o_hit,
    output logic [IDX_W-1:0]             o_index,
    output logic                         o_border
);
    int   w_x, w_y;
    int   w_col_i, w_row_i, w_lx_i, w_ly_i;
    logic w_col_hit, w_row_hit, w_border;

    logic             r_hit;
    logic [IDX_W-1:0] r_index;
    logic             r_border;

    assign w_x = int'(i_x);
    assign w_y = int'(i_y);

    // Range-compare against every column and every row; at most one matches.
    always_comb begin
        w_col_hit = 1'b0;
        w_row_hit = 1'b0;
        w_col_i   = 0;
        w_row_i   = 0;
        w_lx_i    = 0;
        w_ly_i    = 0;
        for (int c = 0; c < TILE_COLS; c++) begin
            if (w_x >= ORIGIN_X + c * (TILE_W + GAP) &&
                w_x <  ORIGIN_X + c * (TILE_W + GAP) + TILE_W) begin
                w_col_hit = 1'b1;
                w_col_i   = c;
                w_lx_i    = w_x - (ORIGIN_X + c * (TILE_W + GAP));
            end
        end
        for (int r = 0; r < TILE_ROWS; r++) begin
            if (w_y >= ORIGIN_Y + r * (TILE_H + GAP) &&
                w_y <  ORIGIN_Y + r * (TILE_H + GAP) + TILE_H) begin
                w_row_hit = 1'b1;
                w_row_i   = r;
                w_ly_i    = w_y - (ORIGIN_Y + r * (TILE_H + GAP));
            end
        end
    end

    assign o_hit_nxt   = w_col_hit & w_row_hit;
    assign o_index_nxt = IDX_W'(w_row_i * TILE_COLS + w_col_i);
    assign o_lx_nxt    = LX_W'(w_lx_i);
    assign o_ly_nxt    = LY_W'(w_ly_i);
    assign w_border    = (w_lx_i < BORDER_W) || (w_lx_i >= TILE_W - BORDER_W) ||
                         (w_ly_i < BORDER_W) || (w_ly_i >= TILE_H - BORDER_W);

    // Register the decode so it lines up with the ROM address register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit    <= 1'b0;
            r_index  <= '0;
            r_border <= 1'b0;
        end else begin
            r_hit    <= o_hit_nxt;
            r_index  <= o_hit_nxt ? o_index_nxt : '0;
            r_border <= o_hit_nxt & w_border;
        end
    end

    assign o_hit    = r_hit;
    assign o_index  = r_index;
    assign o_border = r_border;

endmodule

`default_nettype wire

// File: rtl/vga_tile_compositor.sv
//------------------------------------------------------------------------------
// Module  : vga_tile_compositor
// Brief   : Tile-grid pixel compositor: ROM address generation, flag delay
//           line, frame-synchronous highlight shadow, blink counter and the
//           registered RGB output mux. Latency 2 + ROM_LATENCY.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_tile_compositor
    import vga_tile_pkg::*;
#(
    parameter int R_WIDTH        = 8,
    parameter int G_WIDTH        = 8,
    parameter int B_WIDTH        = 8,
    parameter int CNTR_WIDTH_H   = 11,
    parameter int CNTR_WIDTH_V   = 10,
    parameter int TILE_W         = 100,
    parameter int TILE_H         = 100,
    parameter int TILE_COLS      = 4,
    parameter int TILE_ROWS      = 3,
    parameter int ORIGIN_X       = 40,
    parameter int ORIGIN_Y       = 40,
    parameter int GAP            = 20,
    parameter int BORDER_W       = 4,
    parameter int ROM_ADDR_WIDTH = 17,
    parameter int ROM_LATENCY    = 1,
    parameter int BLINK_FRAMES   = 30
) (
    input  wire logic           CLOCK,
    input  wire logic           RESET,
    vga_tile_compositor_if.slave bus
);
    localparam int NUM_TILES = TILE_COLS * TILE_ROWS;
    localparam int IDX_W     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int LX_W      = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int LY_W      = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam int FC_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int RGB_W     = R_WIDTH + G_WIDTH + B_WIDTH;
    localparam int MIN_TILE  = (TILE_W < TILE_H) ? TILE_W : TILE_H;

    if (!rom_fits(NUM_TILES, TILE_W, TILE_H, ROM_ADDR_WIDTH)) begin : g_err_rom
        $error("image ROM address space too small for the tile grid");
    end
    if (2 * BORDER_W > MIN_TILE) begin : g_err_border
        $error("highlight border thicker than half a tile");
    end
    if (ROM_LATENCY < 1) begin : g_err_latency
        $error("ROM_LATENCY must be at least 1");
    end
    if (R_WIDTH > 16 || G_WIDTH > 16 || B_WIDTH > 16) begin : g_err_chan
        $error("colour channels wider than 16 bits are not supported");
    end

    // Decoder
    logic             w_hit_nxt, w_hit, w_border;
    logic [IDX_W-1:0] w_index_nxt, w_index;
    logic [LX_W-1:0]  w_lx_nxt;
    logic [LY_W-1:0]  w_ly_nxt;

    vga_tile_hit_decoder #(
        .CNTR_WIDTH_H (CNTR_WIDTH_H), .CNTR_WIDTH_V (CNTR_WIDTH_V),
        .TILE_W       (TILE_W),       .TILE_H       (TILE_H),
        .TILE_COLS    (TILE_COLS),    .TILE_ROWS    (TILE_ROWS),
        .ORIGIN_X     (ORIGIN_X),     .ORIGIN_Y     (ORIGIN_Y),
        .GAP          (GAP),          .BORDER_W     (BORDER_W)
    ) u_hit (
        .clk         (CLOCK),
        .rst         (RESET),
        .i_x         (bus.CounterX),
        .i_y         (bus.CounterY),
        .o_hit_nxt   (w_hit_nxt),
        .o_index_nxt (w_index_nxt),
        .o_lx_nxt    (w_lx_nxt),
        .o_ly_nxt    (w_ly_nxt),
        .o_hit       (w_hit),
        .o_index     (w_index),
        .o_border    (w_border)
    );

    // Shadow, blink and stage-1 state
    logic [NUM_TILES-1:0]      r_sh_mask, r_mask1;
    logic [1:0]                r_sh_mode, r_mode1;
    logic [FC_W-1:0]           r_frame_cnt;
    logic                      r_blink, r_blink1, r_valid1;
    logic [ROM_ADDR_WIDTH-1:0] r_addr;

    // Delay line aligning the stage-1 flags with ROM_Data
    logic       r_d_valid  [ROM_LATENCY];
    logic       r_d_hit    [ROM_LATENCY];
    logic       r_d_border [ROM_LATENCY];
    logic       r_d_hl     [ROM_LATENCY];
    logic       r_d_blink  [ROM_LATENCY];
    logic [1:0] r_d_mode   [ROM_LATENCY];

    logic [RGB_W-1:0] r_rgb, w_rgb, w_blend;
    logic             r_rgb_valid;

    // Highlight settings load only at frame start; the blink phase advances every BLINK_FRAMES frames.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_sh_mask   <= '0;
            r_sh_mode   <= HL_NONE;
            r_frame_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (bus.FrameStart) begin
            r_sh_mask <= bus.HighlightMask;
            r_sh_mode <= bus.HighlightMode;
            if (r_frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                r_frame_cnt <= '0;
                r_blink     <= ~r_blink;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    // Stage 1: ROM address plus a snapshot of the settings in force when the pixel was sampled.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_addr   <= '0;
            r_valid1 <= 1'b0;
            r_mask1  <= '0;
            r_mode1  <= HL_NONE;
            r_blink1 <= 1'b0;
        end else begin
            r_addr   <= w_hit_nxt ?
                        ROM_ADDR_WIDTH'(32'(w_index_nxt) * 32'(TILE_W * TILE_H) +
                                        32'(w_ly_nxt) * 32'(TILE_W) + 32'(w_lx_nxt)) : '0;
            r_valid1 <= bus.PixValid;
            r_mask1  <= r_sh_mask;
            r_mode1  <= r_sh_mode;
            r_blink1 <= r_blink;
        end
    end

    // Carry the per-pixel flags through the ROM read latency.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                r_d_valid[i]  <= 1'b0;
                r_d_hit[i]    <= 1'b0;
                r_d_border[i] <= 1'b0;
                r_d_hl[i]     <= 1'b0;
                r_d_blink[i]  <= 1'b0;
                r_d_mode[i]   <= HL_NONE;
            end
        end else begin
            r_d_valid[0]  <= r_valid1;
            r_d_hit[0]    <= w_hit;
            r_d_border[0] <= w_border;
            r_d_hl[0]     <= w_hit & r_mask1[w_index];
            r_d_blink[0]  <= r_blink1;
            r_d_mode[0]   <= r_mode1;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_d_valid[i]  <= r_d_valid[i-1];
                r_d_hit[i]    <= r_d_hit[i-1];
                r_d_border[i] <= r_d_border[i-1];
                r_d_hl[i]     <= r_d_hl[i-1];
                r_d_blink[i]  <= r_d_blink[i-1];
                r_d_mode[i]   <= r_d_mode[i-1];
            end
        end
    end

    assign w_blend = {
        R_WIDTH'(half_blend(16'(bus.ROM_Data[RGB_W-1 -: R_WIDTH]),
                            16'(bus.HighlightColor[RGB_W-1 -: R_WIDTH]))),
        G_WIDTH'(half_blend(16'(bus.ROM_Data[B_WIDTH +: G_WIDTH]),
                            16'(bus.HighlightColor[B_WIDTH +: G_WIDTH]))),
        B_WIDTH'(half_blend(16'(bus.ROM_Data[0 +: B_WIDTH]),
                            16'(bus.HighlightColor[0 +: B_WIDTH])))
    };

    // Output selection in priority order: blanking, background, plain image, highlight styles.
    always_comb begin
        w_rgb = bus.ROM_Data;
        if (!r_d_valid[ROM_LATENCY-1]) begin
            w_rgb = '0;
        end else if (!r_d_hit[ROM_LATENCY-1]) begin
            w_rgb = bus.BgColor;
        end else if (!r_d_hl[ROM_LATENCY-1] || r_d_mode[ROM_LATENCY-1] == HL_NONE) begin
            w_rgb = bus.ROM_Data;
        end else if (r_d_mode[ROM_LATENCY-1] == HL_BORDER) begin
            w_rgb = r_d_border[ROM_LATENCY-1] ? bus.HighlightColor : bus.ROM_Data;
        end else if (r_d_mode[ROM_LATENCY-1] == HL_TINT) begin
            w_rgb = w_blend;
        end else if (r_d_border[ROM_LATENCY-1] && r_d_blink[ROM_LATENCY-1]) begin
            w_rgb = bus.HighlightColor;
        end
    end

    // Registered pixel output.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_rgb       <= '0;
            r_rgb_valid <= 1'b0;
        end else begin
            r_rgb       <= w_rgb;
            r_rgb_valid <= r_d_valid[ROM_LATENCY-1];
        end
    end

    assign bus.ROM_Addr  = r_addr;
    assign bus.RGB_Bus   = r_rgb;
    assign bus.RGB_Valid = r_rgb_valid;

endmodule

`default_nettype wire
